asc_checker: RTL and testbench

ASC_CHECKER -- requirements
Module: asc_checker

---
 rtl/asc_checker.sv | 110 +++++++++++
 tb/tb_asc_checker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/asc_checker.sv
// asc_checker: sequence lock checker for the 5-value counter 0000,1000,0101,1101,0111
module asc_checker #(
   parameter int LOCK_N = 2,
   parameter int LOSS_N = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid,
   input  logic [3:0] din,
   input  logic       clr,
   output logic       locked,
   output logic       err,
   output logic [3:0] expected,
   output logic [2:0] pos,
   output logic [7:0] err_count
);
   typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;
   state_t     state, state_n;
   logic [2:0] pos_n, match, match_n, miss, miss_n, mpos;
   logic [3:0] exp_n;
   logic       err_n, hit, member;

   function automatic logic [2:0] succ(input logic [2:0] p);
      return (p == 3'd4) ? 3'd0 : p + 3'd1;
   endfunction

   function automatic logic [3:0] seq_val(input logic [2:0] p);
      return (p == 3'd1) ? 4'b1000 : (p == 3'd2) ? 4'b0101 :
             (p == 3'd3) ? 4'b1101 : (p == 3'd4) ? 4'b0111 : 4'b0000;
   endfunction

   // decode din into its sequence position and membership
   always_comb begin
      mpos   = (din == 4'b1000) ? 3'd1 : (din == 4'b0101) ? 3'd2 :
               (din == 4'b1101) ? 3'd3 : (din == 4'b0111) ? 3'd4 : 3'd0;
      member = (din == 4'b0000) || (mpos != 3'd0);
      hit    = (din == expected);
   end

   // state, position, counters and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= HUNT;
         pos       <= '0;
         expected  <= '0;
         match     <= '0;
         miss      <= '0;
         err       <= 1'b0;
         err_count <= '0;
      end else begin
         state     <= state_n;
         pos       <= pos_n;
         expected  <= exp_n;
         match     <= match_n;
         miss      <= miss_n;
         err       <= err_n;
         err_count <= clr ? 8'd0 : (err_n && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
      end
   end

   // next-state: hunt for a member, confirm LOCK_N in a row, flywheel while locked
   always_comb begin
      state_n = state;
      pos_n   = pos;
      match_n = match;
      miss_n  = miss;
      err_n   = 1'b0;
      if (valid) begin
         case (state)
            HUNT: if (member) begin
               pos_n   = succ(mpos);
               match_n = 3'd1;
               miss_n  = 3'd0;
               state_n = (LOCK_N == 1) ? LOCK : SYNC;
            end
            SYNC: if (hit) begin
               pos_n   = succ(pos);
               match_n = match + 3'd1;
               miss_n  = 3'd0;
               if ({1'b0, match} + 4'd1 >= 4'(LOCK_N)) state_n = LOCK;
            end else if (member) begin
               pos_n   = succ(mpos);
               match_n = 3'd1;
            end else begin
               state_n = HUNT;
               pos_n   = 3'd0;
               match_n = 3'd0;
            end
            LOCK: begin
               pos_n  = succ(pos);
               miss_n = hit ? 3'd0 : miss + 3'd1;
               err_n  = !hit;
               if (!hit && {1'b0, miss} + 4'd1 >= 4'(LOSS_N)) begin
                  state_n = HUNT;
                  pos_n   = 3'd0;
                  miss_n  = 3'd0;
                  match_n = 3'd0;
               end
            end
            default: state_n = HUNT;
         endcase
      end
   end

   // outputs derived from registered state
   always_comb begin
      exp_n  = seq_val(pos_n);
      locked = (state == LOCK);
   end
endmodule

// File: tb/tb_asc_checker.sv
// tb_asc_checker: randomized and directed checks of asc_checker against a behavioural model
module tb_asc_checker;
   logic       clk, rst, valid, clr;
   logic [3:0] din;
   logic       lk[2], er[2];
   logic [3:0] ex[2];
   logic [2:0] ps[2];
   logic [7:0] ec[2];
   int         pass = 0, total = 0;

   asc_checker #(.LOCK_N(2), .LOSS_N(2)) u0 (.clk(clk), .rst(rst), .valid(valid), .din(din), .clr(clr),
      .locked(lk[0]), .err(er[0]), .expected(ex[0]), .pos(ps[0]), .err_count(ec[0]));
   asc_checker #(.LOCK_N(3), .LOSS_N(7)) u1 (.clk(clk), .rst(rst), .valid(valid), .din(din), .clr(clr),
      .locked(lk[1]), .err(er[1]), .expected(ex[1]), .pos(ps[1]), .err_count(ec[1]));

   initial clk = 0;
   always #5 clk = ~clk;

   typedef struct {int st; int pos; int match; int miss; int err; int cnt;} m_t;
   m_t         m[2];
   int         lock_n[2] = '{2, 3};
   int         loss_n[2] = '{2, 7};
   logic [3:0] sq[5] = '{4'b0000, 4'b1000, 4'b0101, 4'b1101, 4'b0111};

   function automatic void mreset();
      for (int k = 0; k < 2; k++) m[k] = '{0, 0, 0, 0, 0, 0};
   endfunction

   function automatic int idx_of(input logic [3:0] d);
      for (int i = 0; i < 5; i++) if (sq[i] == d) return i;
      return -1;
   endfunction

   // model: st 0=hunt 1=sync 2=locked, positions advance modulo 5
   function automatic void mstep(input bit v, input logic [3:0] d, input bit c);
      for (int k = 0; k < 2; k++) begin
         int ix = idx_of(d);
         bit h  = (d == sq[m[k].pos]);
         m[k].err = 0;
         if (v) begin
            if (m[k].st == 0) begin
               if (ix >= 0) begin
                  m[k].pos = (ix + 1) % 5; m[k].match = 1; m[k].miss = 0;
                  m[k].st = (lock_n[k] == 1) ? 2 : 1;
               end
            end else if (m[k].st == 1) begin
               if (h) begin
                  m[k].pos = (m[k].pos + 1) % 5; m[k].match++;
                  if (m[k].match >= lock_n[k]) begin m[k].st = 2; m[k].miss = 0; end
               end else if (ix >= 0) begin
                  m[k].pos = (ix + 1) % 5; m[k].match = 1;
               end else begin
                  m[k].st = 0; m[k].pos = 0; m[k].match = 0;
               end
            end else begin
               m[k].pos = (m[k].pos + 1) % 5;
               if (h) m[k].miss = 0;
               else begin
                  m[k].err = 1; m[k].miss++;
                  if (m[k].miss >= loss_n[k]) begin m[k].st = 0; m[k].pos = 0; m[k].miss = 0; m[k].match = 0; end
               end
            end
         end
         if (c) m[k].cnt = 0;
         else if (m[k].err == 1 && m[k].cnt < 255) m[k].cnt++;
      end
   endfunction

   function automatic logic [16:0] mvec(input int k);
      return {m[k].st == 2, m[k].err == 1, sq[m[k].pos], 3'(m[k].pos), 8'(m[k].cnt)};
   endfunction

   function automatic logic [16:0] dvec(input int k);
      return {lk[k], er[k], ex[k], ps[k], ec[k]};
   endfunction

   task automatic cyc(input bit v, input logic [3:0] d, input bit c);
      @(negedge clk);
      valid = v; din = d; clr = c;
      @(posedge clk);
      mstep(v, d, c);
      #1;
   endtask

   task automatic test_reset();
      rst = 0; valid = 0; din = 0; clr = 0;
      mreset();
      #3;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (dvec(k) !== 17'd0) $display("FAIL reset[%0d] got %h want 0", k, dvec(k));
         else pass++;
      end
      @(negedge clk); rst = 1;
   endtask

   task automatic test_lock();
      logic [3:0] s[3] = '{4'b0000, 4'b1000, 4'b0101};
      for (int i = 0; i < 3; i++) begin
         cyc(1, s[i], 0);
         for (int k = 0; k < 2; k++) begin
            total++;
            if (dvec(k) !== mvec(k)) $display("FAIL lock_model[%0d] step %0d got %h want %h", k, i, dvec(k), mvec(k));
            else pass++;
         end
         if (i == 1) begin
            total++;
            if (lk[0] !== 1'b1) $display("FAIL lock_after_1000 got %b want 1", lk[0]);
            else pass++;
         end
      end
      total++;
      if (ex[0] !== 4'b1101 || ps[0] !== 3'd3 || er[0] !== 1'b0)
         $display("FAIL lock_expected got %b/%0d err %b want 1101/3 err 0", ex[0], ps[0], er[0]);
      else pass++;
   endtask

   task automatic test_flywheel();
      logic [3:0] s[3] = '{4'b1101, 4'b0011, 4'b0000};
      for (int i = 0; i < 3; i++) begin
         cyc(1, s[i], 0);
         for (int k = 0; k < 2; k++) begin
            total++;
            if (dvec(k) !== mvec(k)) $display("FAIL flywheel_model[%0d] step %0d got %h want %h", k, i, dvec(k), mvec(k));
            else pass++;
         end
         if (i == 1) begin
            total++;
            if (er[0] !== 1'b1 || ex[0] !== 4'b0000 || ec[0] !== 8'd1 || lk[0] !== 1'b1)
               $display("FAIL flywheel_err got err %b exp %b cnt %0d lk %b want 1 0000 1 1", er[0], ex[0], ec[0], lk[0]);
            else pass++;
         end
      end
   endtask

   task automatic test_loss();
      for (int i = 0; i < 2; i++) begin
         cyc(1, 4'b1111, 0);
         for (int k = 0; k < 2; k++) begin
            total++;
            if (dvec(k) !== mvec(k)) $display("FAIL loss_model[%0d] step %0d got %h want %h", k, i, dvec(k), mvec(k));
            else pass++;
         end
      end
      total++;
      if (er[0] !== 1'b1 || lk[0] !== 1'b0 || ex[0] !== 4'b0000 || ec[0] !== 8'd3)
         $display("FAIL loss_state got err %b lk %b exp %b cnt %0d want 1 0 0000 3", er[0], lk[0], ex[0], ec[0]);
      else pass++;
   endtask

   task automatic test_hunt();
      logic [3:0] s[4] = '{4'b1010, 4'b0110, 4'b0111, 4'b0000};
      for (int i = 0; i < 4; i++) begin
         cyc(1, s[i], 0);
         for (int k = 0; k < 2; k++) begin
            total++;
            if (dvec(k) !== mvec(k)) $display("FAIL hunt_model[%0d] step %0d got %h want %h", k, i, dvec(k), mvec(k));
            else pass++;
         end
         if (i < 3) begin
            total++;
            if (lk[0] !== 1'b0 || ex[0] !== 4'b0000 || er[0] !== 1'b0)
               $display("FAIL hunt_step%0d got lk %b exp %b err %b want 0 0000 0", i, lk[0], ex[0], er[0]);
            else pass++;
         end
      end
      total++;
      if (lk[0] !== 1'b1) $display("FAIL hunt_lock got %b want 1", lk[0]);
      else pass++;
   endtask

   task automatic test_gaps();
      for (int i = 0; i < 6; i++) begin
         cyc(0, 4'($urandom), 0);
         for (int k = 0; k < 2; k++) begin
            total++;
            if (dvec(k) !== mvec(k) || er[k] !== 1'b0) $display("FAIL gap_hold[%0d] got %h want %h", k, dvec(k), mvec(k));
            else pass++;
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 9) != 0, ($urandom_range(0, 2) != 0) ? sq[m[0].pos] : 4'($urandom),
             $urandom_range(0, 40) == 0);
         for (int k = 0; k < 2; k++) begin
            total++;
            if (dvec(k) !== mvec(k)) $display("FAIL random[%0d] cycle %0d got %h want %h", k, i, dvec(k), mvec(k));
            else pass++;
         end
      end
   endtask

   task automatic test_saturate();
      int n = 0;
      @(negedge clk); rst = 0; mreset();
      @(negedge clk); rst = 1;
      while (m[1].st != 2 && n < 10) begin cyc(1, sq[m[1].pos], 0); n++; end
      total++;
      if (lk[1] !== 1'b1) $display("FAIL sat_lock got %b want 1", lk[1]);
      else pass++;
      for (int i = 0; i < 300; i++) begin
         cyc(1, sq[m[1].pos] ^ 4'hF, 0);
         cyc(1, sq[m[1].pos], 0);
         for (int k = 0; k < 2; k++) begin
            total++;
            if (dvec(k) !== mvec(k)) $display("FAIL sat_model[%0d] iter %0d got %h want %h", k, i, dvec(k), mvec(k));
            else pass++;
         end
      end
      total++;
      if (ec[1] !== 8'd255 || lk[1] !== 1'b1) $display("FAIL sat_count got %0d lk %b want 255 1", ec[1], lk[1]);
      else pass++;
      cyc(1, sq[m[1].pos] ^ 4'hF, 1);
      total++;
      if (ec[1] !== 8'd0 || er[1] !== 1'b1) $display("FAIL sat_clr got cnt %0d err %b want 0 1", ec[1], er[1]);
      else pass++;
   endtask

   task automatic test_async_reset();
      cyc(1, sq[m[0].pos], 0);
      cyc(1, sq[m[0].pos], 0);
      cyc(1, sq[m[0].pos], 0);
      total++;
      if (lk[0] !== 1'b1) $display("FAIL areset_prelock got %b want 1", lk[0]);
      else pass++;
      @(posedge clk); #3;
      rst = 0;
      mreset();
      #1;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (dvec(k) !== 17'd0) $display("FAIL areset_async[%0d] got %h want 0", k, dvec(k));
         else pass++;
      end
      @(negedge clk);
      rst = 1; valid = 1; din = 4'b0000; clr = 0;
      @(posedge clk);
      mstep(1, 4'b0000, 0);
      #1;
      total++;
      if (ex[0] !== 4'b1000 || ps[0] !== 3'd1 || lk[0] !== 1'b0)
         $display("FAIL areset_first_edge got exp %b pos %0d lk %b want 1000 1 0", ex[0], ps[0], lk[0]);
      else pass++;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (dvec(k) !== mvec(k)) $display("FAIL areset_model[%0d] got %h want %h", k, dvec(k), mvec(k));
         else pass++;
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_flywheel();
      test_loss();
      test_hunt();
      test_gaps();
      test_random();
      test_saturate();
      test_async_reset();
      test_gaps();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
